// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the multi-master bus arbiter.
// The optional round-robin mode is selected with BUS_ARBITER_ROUND_ROBIN_EN.
package bus_arbiter_pkg;

  localparam int ARB_DEFAULT_MASTERS    = 4;
  localparam int ARB_DEFAULT_ADDR_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_priority_picker.sv
// Combinational picker: first asserted request at or after a start index,
// wrapping modulo N. A start of zero gives plain lowest-index-wins priority.
module arb_priority_picker #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] start,
  output logic          valid,
  output logic [IW-1:0] index
);

  localparam logic [IW:0] N_W = (IW + 1)'(N);

  // One spare bit so start + offset never overflows before the wrap.
  logic [IW:0] cand;

  // NOTE: every output and temporary gets a default before the loop, so no
  // path through this block can leave a value held (which would infer a latch).
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, start} + (IW + 1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (!valid && request[cand[IW-1:0]]) begin
        valid = 1'b1;
        index = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/multi_master_bus_arbiter.sv
// Arbitrates the CPU address/command bus among MASTERS requesters with a
// bounded, lockable tenure. Define BUS_ARBITER_ROUND_ROBIN_EN for rotating priority.
module multi_master_bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter  int MASTERS    = ARB_DEFAULT_MASTERS,
  parameter  int ADDR_WIDTH = ARB_DEFAULT_ADDR_WIDTH,
  parameter  int MAX_TENURE = 16,
  localparam int IDX_W      = (MASTERS > 1) ? $clog2(MASTERS) : 1,
  localparam int CNT_W      = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [2:0]                    processor_status,
  input  logic                          processor_lock_n,
  input  logic [MASTERS-1:0]            request,
  input  logic [MASTERS-1:0]            master_lock,
  input  logic [MASTERS*ADDR_WIDTH-1:0] master_address,
  input  logic [ADDR_WIDTH-1:0]         cpu_address,
  output logic [MASTERS-1:0]            grant,
  output logic [IDX_W-1:0]              owner_index,
  output logic                          address_enable_n,
  output logic                          bus_wait_n,
  output logic [ADDR_WIDTH-1:0]         address
);

  localparam logic [CNT_W-1:0]   TENURE_LAST = CNT_W'(MAX_TENURE - 1);
  localparam logic [IDX_W-1:0]   LAST_MASTER = IDX_W'(MASTERS - 1);
  localparam logic [MASTERS-1:0] GRANT_ONE   = MASTERS'(1);

  arb_state_t        state;
  logic [CNT_W-1:0]  tenure_count;
  logic [IDX_W-1:0]  pick_start;
  logic [IDX_W-1:0]  pick_index;
  logic              pick_valid;
  logic              cpu_passive;
  logic              arb_go;
  logic              tenure_end;
  logic              status_unused;

  // Only S1..S0 decide passivity; S2 is carried for completeness.
  assign status_unused = processor_status[2];
  assign cpu_passive   = (processor_status[1:0] == 2'b11);

  // Entering IDLE always takes an edge, so any IDLE cycle seen here has
  // already lasted one full cycle.
  assign arb_go = (state == IDLE) && pick_valid && cpu_passive && processor_lock_n;

  assign tenure_end = !request[owner_index] ||
                      ((tenure_count == TENURE_LAST) && !master_lock[owner_index]);

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_pointer;
  logic [IDX_W-1:0] rr_next;

  assign pick_start = rr_pointer;
  assign rr_next    = (owner_index == LAST_MASTER) ? '0 : owner_index + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_pointer <= '0;
    end else if (state == GRANT && tenure_end) begin
      rr_pointer <= rr_next;
    end
  end
`else
  logic unused_last_master;

  assign pick_start         = '0;
  assign unused_last_master = ^LAST_MASTER;
`endif

  arb_priority_picker #(
    .N (MASTERS)
  ) u_picker (
    .request (request),
    .start   (pick_start),
    .valid   (pick_valid),
    .index   (pick_index)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      grant            <= '0;
      owner_index      <= '0;
      tenure_count     <= '0;
      address_enable_n <= 1'b0;
      bus_wait_n       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (arb_go) begin
            state            <= HOLD;
            owner_index      <= pick_index;
            address_enable_n <= 1'b1;
            bus_wait_n       <= 1'b0;
          end
        end

        HOLD: begin
          if (request[owner_index]) begin
            state        <= GRANT;
            grant        <= GRANT_ONE << owner_index;
            tenure_count <= '0;
            bus_wait_n   <= 1'b1;
          end else begin
            state <= RELEASE;
          end
        end

        GRANT: begin
          if (tenure_end) begin
            state      <= RELEASE;
            grant      <= '0;
            bus_wait_n <= 1'b0;
          end else if (tenure_count != TENURE_LAST) begin
            // Saturates while a locked owner keeps the bus past its limit.
            tenure_count <= tenure_count + 1'b1;
          end
        end

        RELEASE: begin
          state            <= IDLE;
          grant            <= '0;
          address_enable_n <= 1'b0;
          bus_wait_n       <= 1'b1;
        end

        default: begin
          state            <= IDLE;
          grant            <= '0;
          address_enable_n <= 1'b0;
          bus_wait_n       <= 1'b1;
        end
      endcase
    end
  end

  logic [ADDR_WIDTH-1:0] master_addr_arr [MASTERS];

  for (genvar g = 0; g < MASTERS; g++) begin : g_addr
    assign master_addr_arr[g] = master_address[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // The CPU drives the bus only in IDLE; every other state belongs to the owner.
  always_comb begin
    address = cpu_address;
    if (state != IDLE) address = master_addr_arr[owner_index];
  end

endmodule

// File: tb/tb_multi_master_bus_arbiter.sv
// Directed bench for multi_master_bus_arbiter: a scoreboard of expected grant
// owners is filled as requests are driven and drained by a grant-edge monitor.
module tb_multi_master_bus_arbiter;

  localparam int MASTERS    = 4;
  localparam int ADDR_WIDTH = 20;
  localparam int MAX_TENURE = 4;
  localparam int IDX_W      = 2;

  logic                          clock = 1'b0;
  logic                          reset;
  logic [2:0]                    processor_status;
  logic                          processor_lock_n;
  logic [MASTERS-1:0]            request;
  logic [MASTERS-1:0]            master_lock;
  logic [MASTERS*ADDR_WIDTH-1:0] master_address;
  logic [ADDR_WIDTH-1:0]         cpu_address;
  logic [MASTERS-1:0]            grant;
  logic [IDX_W-1:0]              owner_index;
  logic                          address_enable_n;
  logic                          bus_wait_n;
  logic [ADDR_WIDTH-1:0]         address;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int rr_ptr   = 0;
  int gcount;
  logic [MASTERS-1:0] prev_grant = '0;

  always #5 clock = ~clock;

  multi_master_bus_arbiter #(
    .MASTERS    (MASTERS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_TENURE (MAX_TENURE)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .processor_status (processor_status),
    .processor_lock_n (processor_lock_n),
    .request          (request),
    .master_lock      (master_lock),
    .master_address   (master_address),
    .cpu_address      (cpu_address),
    .grant            (grant),
    .owner_index      (owner_index),
    .address_enable_n (address_enable_n),
    .bus_wait_n       (bus_wait_n),
    .address          (address)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_WIDTH-1:0] maddr(input int i);
    return ADDR_WIDTH'(32'hA0000 + i * 32'h1111);
  endfunction

  // Reference winner selection; the rotating pointer advances per completed tenure.
  task automatic push_expected(input logic [MASTERS-1:0] req);
    int w;
    w = -1;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    for (int k = 0; k < MASTERS; k++) begin
      if (w < 0 && req[(rr_ptr + k) % MASTERS]) w = (rr_ptr + k) % MASTERS;
    end
    rr_ptr = (w + 1) % MASTERS;
`else
    for (int k = MASTERS - 1; k >= 0; k--) begin
      if (req[k]) w = k;
    end
`endif
    exp_q.push_back(w);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Grant-edge monitor: each new grant must match the oldest expected owner.
  always @(negedge clock) begin
    int w;
    if (reset) begin
      prev_grant = '0;
    end else begin
      if (grant != '0 && prev_grant == '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(grant), 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("sb_grant", 32'(grant), 32'(1) << w);
          check("sb_owner", 32'(owner_index), 32'(w));
          check("sb_address", 32'(address), 32'(maddr(w)));
        end
      end
      prev_grant = grant;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    processor_status = 3'b111;
    processor_lock_n = 1'b1;
    request          = '0;
    master_lock      = '0;
    cpu_address      = 20'h12345;
    for (int i = 0; i < MASTERS; i++) master_address[i*ADDR_WIDTH +: ADDR_WIDTH] = maddr(i);

    // Reset state
    step(2);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_owner", 32'(owner_index), 32'd0);
    check("rst_aen_n", 32'(address_enable_n), 32'd0);
    check("rst_bw_n", 32'(bus_wait_n), 32'd1);
    reset = 1'b0;
    check("idle_address", 32'(address), 32'h12345);

    // Lowest asserted request wins; one HOLD cycle precedes the grant
    request = 4'b0110;
    push_expected(request);
    step();
    check("t1_hold_aen_n", 32'(address_enable_n), 32'd1);
    check("t1_hold_bw_n", 32'(bus_wait_n), 32'd0);
    check("t1_hold_grant", 32'(grant), 32'd0);
    check("t1_hold_owner", 32'(owner_index), 32'd1);
    check("t1_hold_address", 32'(address), 32'(maddr(1)));
    step();
    check("t1_grant", 32'(grant), 32'b0010);
    check("t1_grant_bw_n", 32'(bus_wait_n), 32'd1);
    request = '0;
    step();
    check("t1_release_grant", 32'(grant), 32'd0);
    check("t1_release_bw_n", 32'(bus_wait_n), 32'd0);
    step();
    check("t1_idle_aen_n", 32'(address_enable_n), 32'd0);
    check("t1_idle_address", 32'(address), 32'h12345);

    // Request withdrawn during HOLD: no grant pulse, two wait cycles
    request = 4'b0100;
    step();
    check("t2_hold_owner", 32'(owner_index), 32'd2);
    check("t2_hold_bw_n", 32'(bus_wait_n), 32'd0);
    request = '0;
    step();
    check("t2_release_grant", 32'(grant), 32'd0);
    check("t2_release_bw_n", 32'(bus_wait_n), 32'd0);
    step();
    check("t2_idle_bw_n", 32'(bus_wait_n), 32'd1);
    check("t2_idle_aen_n", 32'(address_enable_n), 32'd0);

    // Non-passive status and CPU lock both defer arbitration
    processor_status = 3'b100;
    request          = 4'b0001;
    step(2);
    check("t3_status_aen_n", 32'(address_enable_n), 32'd0);
    check("t3_status_bw_n", 32'(bus_wait_n), 32'd1);
    processor_status = 3'b111;
    processor_lock_n = 1'b0;
    step(2);
    check("t3_lock_aen_n", 32'(address_enable_n), 32'd0);
    check("t3_lock_grant", 32'(grant), 32'd0);
    processor_lock_n = 1'b1;
    push_expected(request);
    step();
    check("t3_unlock_hold_aen_n", 32'(address_enable_n), 32'd1);
    check("t3_unlock_hold_owner", 32'(owner_index), 32'd0);

    // Tenure limit: CPU lock/status changes after HOLD must not matter
    processor_lock_n = 1'b0;
    processor_status = 3'b000;
    gcount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (grant == 4'b0001) gcount++;
      else break;
    end
    check("t3_tenure_cycles", 32'(gcount), 32'(MAX_TENURE));
    check("t3_limit_release_bw_n", 32'(bus_wait_n), 32'd0);
    processor_lock_n = 1'b1;
    processor_status = 3'b111;
    step();
    check("t3_idle_between", 32'(address_enable_n), 32'd0);
    push_expected(request);
    step();
    check("t3_regrant_hold_owner", 32'(owner_index), 32'd0);
    step();
    check("t3_regrant", 32'(grant), 32'b0001);
    request = '0;
    step(2);

    // All masters requesting: successive grants follow the active policy
    reset = 1'b1;
    rr_ptr = 0;
    step();
    check("t4_reset_grant", 32'(grant), 32'd0);
    reset   = 1'b0;
    request = 4'b1111;
    for (int i = 0; i < 5; i++) push_expected(request);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("t4_all_grants_seen", 32'(exp_q.size()), 32'd0);
    request = '0;
    step(2);
    check("t4_idle_aen_n", 32'(address_enable_n), 32'd0);

    // Locked owner keeps the bus past its limit; reset still drops it at once
    request     = 4'b0010;
    master_lock = 4'b0010;
    push_expected(request);
    step(2);
    step(2 * MAX_TENURE);
    check("t5_locked_grant", 32'(grant), 32'b0010);
    reset = 1'b1;
    step();
    check("t5_reset_grant", 32'(grant), 32'd0);
    check("t5_reset_aen_n", 32'(address_enable_n), 32'd0);
    check("t5_reset_bw_n", 32'(bus_wait_n), 32'd1);
    check("t5_reset_owner", 32'(owner_index), 32'd0);
    reset       = 1'b0;
    request     = '0;
    master_lock = '0;
    step(2);
    check("t5_idle_after_reset", 32'(address_enable_n), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
